// File: rtl/fp_issue_arbiter.sv
// Round-robin arbiter sharing one fp_unit execute port between NREQ requesters.
// Optional FPU watchdog: define FP_ARB_TIMEOUT_EN (adds TIMEOUT parameter and timeout_err port).
module fp_issue_arbiter #(
   parameter int NREQ = 4
`ifdef FP_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT = 1024
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*64-1:0]   req_data1,
   input  logic [NREQ*64-1:0]   req_data2,
   input  logic [NREQ*64-1:0]   req_data3,
   input  logic [NREQ*2-1:0]    req_fmt,
   input  logic [NREQ*3-1:0]    req_rm,
   input  logic [NREQ*10-1:0]   req_opcode,
   input  logic [NREQ*2-1:0]    req_op,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [63:0]          resp_result,
   output logic [4:0]           resp_flags,
   output logic                 fpu_enable,
   output logic [63:0]          fpu_data1,
   output logic [63:0]          fpu_data2,
   output logic [63:0]          fpu_data3,
   output logic [1:0]           fpu_fmt,
   output logic [2:0]           fpu_rm,
   output logic [9:0]           fpu_opcode,
   output logic [1:0]           fpu_op,
   input  logic [63:0]          fpu_result,
   input  logic [4:0]           fpu_flags,
   input  logic                 fpu_ready,
   output logic                 busy
`ifdef FP_ARB_TIMEOUT_EN
   ,output logic                timeout_err
`endif
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]     state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt;
   logic [IDW-1:0] sel;
   logic           found;
   logic [IDW-1:0] rr_next;

`ifdef FP_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
   logic             terr;
`endif

   // Search upward from rr_ptr, wrapping at NREQ, for the first valid requester.
   always_comb begin
      int idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IDW-1:0];
         end
      end
   end

   assign rr_next = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i]  = reset && (state == S_IDLE) && found && (sel == IDW'(i));
         resp_valid[i] = (state == S_RESP) && (gnt == IDW'(i));
      end
   end

   assign fpu_enable = (state == S_ISSUE);
   assign busy       = (state != S_IDLE);

`ifdef FP_ARB_TIMEOUT_EN
   assign timeout_err = (state == S_RESP) && terr;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         gnt         <= '0;
         fpu_data1   <= '0;
         fpu_data2   <= '0;
         fpu_data3   <= '0;
         fpu_fmt     <= '0;
         fpu_rm      <= '0;
         fpu_opcode  <= '0;
         fpu_op      <= '0;
         resp_result <= '0;
         resp_flags  <= '0;
`ifdef FP_ARB_TIMEOUT_EN
         cnt         <= '0;
         terr        <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  fpu_data1  <= req_data1[sel*64 +: 64];
                  fpu_data2  <= req_data2[sel*64 +: 64];
                  fpu_data3  <= req_data3[sel*64 +: 64];
                  fpu_fmt    <= req_fmt[sel*2 +: 2];
                  fpu_rm     <= req_rm[sel*3 +: 3];
                  fpu_opcode <= req_opcode[sel*10 +: 10];
                  fpu_op     <= req_op[sel*2 +: 2];
                  gnt        <= sel;
                  state      <= S_ISSUE;
`ifdef FP_ARB_TIMEOUT_EN
                  cnt        <= '0;
                  terr       <= 1'b0;
`endif
               end
            end
            S_ISSUE, S_WAIT: begin
               if (fpu_ready) begin
                  resp_result <= fpu_result;
                  resp_flags  <= fpu_flags;
                  state       <= S_RESP;
               end
`ifdef FP_ARB_TIMEOUT_EN
               // A hung FPU is reported to the requester as an invalid-operation result.
               else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  resp_result <= '0;
                  resp_flags  <= 5'b10000;
                  terr        <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  cnt   <= cnt + CNT_W'(1);
                  state <= S_WAIT;
               end
`else
               else begin
                  state <= S_WAIT;
               end
`endif
            end
            S_RESP: begin
               if (resp_ready[gnt]) begin
                  rr_ptr <= rr_next;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Scoreboard bench for fp_issue_arbiter: directed ops, a scripted FPU model, and a response monitor.
module tb_fp_issue_arbiter;

   localparam int NREQ = 4;

   logic                clock = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ready;
   logic [NREQ*64-1:0]  req_data1, req_data2, req_data3;
   logic [NREQ*2-1:0]   req_fmt, req_op;
   logic [NREQ*3-1:0]   req_rm;
   logic [NREQ*10-1:0]  req_opcode;
   logic [63:0]         resp_result;
   logic [4:0]          resp_flags;
   logic                fpu_enable;
   logic [63:0]         fpu_data1, fpu_data2, fpu_data3;
   logic [1:0]          fpu_fmt, fpu_op;
   logic [2:0]          fpu_rm;
   logic [9:0]          fpu_opcode;
   logic [63:0]         fpu_result;
   logic [4:0]          fpu_flags;
   logic                fpu_ready;
   logic                busy;
`ifdef FP_ARB_TIMEOUT_EN
   logic                timeout_err;
`endif

   fp_issue_arbiter #(
      .NREQ(NREQ)
`ifdef FP_ARB_TIMEOUT_EN
      ,.TIMEOUT(16)
`endif
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
      .req_fmt(req_fmt), .req_rm(req_rm), .req_opcode(req_opcode), .req_op(req_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_flags(resp_flags),
      .fpu_enable(fpu_enable),
      .fpu_data1(fpu_data1), .fpu_data2(fpu_data2), .fpu_data3(fpu_data3),
      .fpu_fmt(fpu_fmt), .fpu_rm(fpu_rm), .fpu_opcode(fpu_opcode), .fpu_op(fpu_op),
      .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready),
      .busy(busy)
`ifdef FP_ARB_TIMEOUT_EN
      ,.timeout_err(timeout_err)
`endif
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          idx;
      logic [63:0] res;
      logic [4:0]  flg;
      logic        terr;
   } resp_t;

   typedef struct {
      logic [63:0] d1, d2, d3;
      logic [16:0] ctrl;
   } iss_t;

   resp_t exp_q[$];
   iss_t  iss_q[$];

   // FPU model configuration: lat 0 = ready in the issue cycle, <0 = never ready
   int          lat_cfg  = 3;
   logic        fixed_en = 1'b0;
   logic [63:0] fixed_res = '0;
   logic [4:0]  fixed_flg = '0;
   int          pend = -1;

   initial begin
      iss_t is;
      fpu_ready  = 1'b0;
      fpu_result = '0;
      fpu_flags  = '0;
      forever begin
         @(negedge clock);
         fpu_ready = 1'b0;
         if (fpu_enable) begin
            if (iss_q.size() == 0) begin
               check("issue_expected", 64'(iss_q.size()), 64'd1);
            end else begin
               is = iss_q.pop_front();
               check("issue_data1", fpu_data1, is.d1);
               check("issue_data2", fpu_data2, is.d2);
               check("issue_data3", fpu_data3, is.d3);
               check("issue_ctrl", 64'({fpu_fmt, fpu_rm, fpu_opcode, fpu_op}), 64'(is.ctrl));
            end
            fpu_result = fixed_en ? fixed_res : ~fpu_data1;
            fpu_flags  = fixed_en ? fixed_flg : fpu_data1[4:0];
            if (lat_cfg == 0) fpu_ready = 1'b1;
            else if (lat_cfg > 0) pend = lat_cfg;
            else pend = -1;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               fpu_ready = 1'b1;
               pend = -1;
            end
         end
      end
   end

   // Response monitor: every accepted response is matched against the scoreboard.
   initial begin
      resp_t e;
      forever begin
         @(negedge clock);
         if ((resp_valid & resp_ready) != '0) begin
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("resp_valid", 64'(resp_valid), 64'd1 << e.idx);
               check("resp_result", resp_result, e.res);
               check("resp_flags", 64'(resp_flags), 64'(e.flg));
`ifdef FP_ARB_TIMEOUT_EN
               check("timeout_err", 64'(timeout_err), 64'(e.terr));
`endif
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] d3, input logic [1:0] fmt, input logic [2:0] rm,
                          input logic [9:0] opc, input logic [1:0] op);
      req_data1[i*64 +: 64]  = d1;
      req_data2[i*64 +: 64]  = d2;
      req_data3[i*64 +: 64]  = d3;
      req_fmt[i*2 +: 2]      = fmt;
      req_rm[i*3 +: 3]       = rm;
      req_opcode[i*10 +: 10] = opc;
      req_op[i*2 +: 2]       = op;
   endtask

   task automatic push_issue(input int i);
      iss_t is;
      is.d1   = req_data1[i*64 +: 64];
      is.d2   = req_data2[i*64 +: 64];
      is.d3   = req_data3[i*64 +: 64];
      is.ctrl = {req_fmt[i*2 +: 2], req_rm[i*3 +: 3], req_opcode[i*10 +: 10], req_op[i*2 +: 2]};
      iss_q.push_back(is);
   endtask

   task automatic push_resp(input int i, input int lat);
      resp_t e;
      e.idx  = i;
      e.terr = (lat < 0);
      e.res  = (lat < 0) ? 64'd0 : (fixed_en ? fixed_res : ~req_data1[i*64 +: 64]);
      e.flg  = (lat < 0) ? 5'b10000 : (fixed_en ? fixed_flg : req_data1[i*64 +: 5]);
      exp_q.push_back(e);
   endtask

   task automatic wait_accept(input string name, input logic [NREQ-1:0] want);
      for (int c = 0; c < 60; c++) begin
         @(negedge clock);
         if (req_ready != '0) break;
      end
      check(name, 64'(req_ready), 64'(want));
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 100; c++) begin
         if (exp_q.size() == 0) break;
         @(negedge clock);
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clock);
      #1;
   endtask

   // Single op from requester i; returns cycles from accept to first resp_valid.
   task automatic do_op(input int i, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [9:0] opc, input logic [1:0] fmt, input int lat,
                        input logic fix, input logic [63:0] res, input logic [4:0] flg,
                        output int lat_seen);
      int k;
      lat_cfg = lat; fixed_en = fix; fixed_res = res; fixed_flg = flg;
      set_req(i, d1, d2, 64'h0, fmt, 3'd0, opc, 2'd0);
      req_valid[i] = 1'b1;
      wait_accept($sformatf("accept_req%0d", i), NREQ'(1) << i);
      push_issue(i);
      push_resp(i, lat);
      @(posedge clock);
      #1;
      req_valid[i] = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 1) check("enable_pulse", 64'(fpu_enable), 64'd1);
         if (resp_valid != '0) break;
      end
      lat_seen = k;
      @(posedge clock);
      #1;
   endtask

   task automatic rr_run(input logic [NREQ-1:0] mask, input int n, input int order[8]);
      for (int i = 0; i < NREQ; i++)
         set_req(i, 64'hDA7A_0000_0000_0000 | 64'(i * 16 + 3), 64'(i + 7), 64'(i), 2'd1,
                 3'(i), 10'h002 << i, 2'(i));
      lat_cfg = 1; fixed_en = 1'b0;
      req_valid = mask;
      for (int k = 0; k < n; k++) begin
         wait_accept($sformatf("rr_grant%0d", k), NREQ'(1) << order[k]);
         push_issue(order[k]);
         push_resp(order[k], 1);
         @(posedge clock);
         #1;
         if (k == n - 1) req_valid = '0;
      end
      wait_drain();
   endtask

   initial begin
      int          lat_seen;
      logic [63:0] r0;
      logic [4:0]  f0;
      logic [NREQ-1:0] v0;

      reset = 1'b0;
      req_valid = '1;
      resp_ready = '1;
      req_data1 = '0; req_data2 = '0; req_data3 = '0;
      req_fmt = '0; req_rm = '0; req_opcode = '0; req_op = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_enable", 64'(fpu_enable), 64'd0);
      check("rst_fpu_data1", fpu_data1, 64'd0);
      check("rst_resp_result", resp_result, 64'd0);
      @(posedge clock);
      #1;
      req_valid = '0;
      reset = 1'b1;

      // double-precision fadd 1.0 + 2.0 = 3.0 from requester 2
      do_op(2, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 10'h002, 2'd1, 3,
            1'b1, 64'h4008_0000_0000_0000, 5'd0, lat_seen);
      check("fadd_latency", 64'(lat_seen), 64'd5);

      // fcmp answered in the issue cycle
      do_op(0, 64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000, 10'h040, 2'd0, 0,
            1'b1, 64'h1, 5'b00000, lat_seen);
      check("fast_latency", 64'(lat_seen), 64'd2);

      // backpressure with requester 3 waiting
      resp_ready = '0;
      lat_cfg = 2; fixed_en = 1'b0;
      set_req(1, 64'h1111_2222_3333_4445, 64'h5, 64'h6, 2'd1, 3'd2, 10'h008, 2'd0);
      set_req(3, 64'h7777_8888_9999_AAA6, 64'h7, 64'h8, 2'd0, 3'd1, 10'h200, 2'd3);
      req_valid[1] = 1'b1;
      wait_accept("bp_accept1", 4'b0010);
      push_issue(1);
      push_resp(1, 2);
      @(posedge clock);
      #1;
      req_valid[1] = 1'b0;
      req_valid[3] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (resp_valid != '0) break;
      end
      v0 = resp_valid; r0 = resp_result; f0 = resp_flags;
      check("bp_valid_seen", 64'(v0), 64'b0010);
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         check("bp_valid_stable", 64'(resp_valid), 64'(v0));
         check("bp_result_stable", resp_result, r0);
         check("bp_flags_stable", 64'(resp_flags), 64'(f0));
         check("bp_no_enable", 64'(fpu_enable), 64'd0);
         check("bp_no_grant", 64'(req_ready), 64'd0);
      end
      @(posedge clock);
      #1;
      resp_ready = '1;
      wait_accept("bp_accept3", 4'b1000);
      push_issue(3);
      push_resp(3, 2);
      @(posedge clock);
      #1;
      req_valid[3] = 1'b0;
      wait_drain();

      // rr_ptr is now 0: full contention
      rr_run(4'b1111, 5, '{0, 1, 2, 3, 0, 0, 0, 0});

      do_op(1, 64'h0123_4567_89AB_CDE9, 64'h2, 10'h010, 2'd1, 1, 1'b0, 64'h0, 5'd0, lat_seen);
      check("op1_latency", 64'(lat_seen), 64'd3);

      // reset during a pending fdiv; the late fpu_ready must be ignored
      lat_cfg = 8; fixed_en = 1'b0;
      set_req(2, 64'h4024_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h0, 2'd1, 3'd0, 10'h010, 2'd0);
      req_valid[2] = 1'b1;
      wait_accept("div_accept", 4'b0100);
      push_issue(2);
      @(posedge clock);
      #1;
      req_valid[2] = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("div_busy_before_reset", 64'(busy), 64'd1);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (8) @(negedge clock);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_resp_valid", 64'(resp_valid), 64'd0);
      check("post_rst_enable", 64'(fpu_enable), 64'd0);
      check("post_rst_fpu_data1", fpu_data1, 64'd0);
      check("post_rst_opcode", 64'(fpu_opcode), 64'd0);
      check("post_rst_result", resp_result, 64'd0);
      check("post_rst_flags", 64'(resp_flags), 64'd0);
      @(posedge clock);
      #1;

      // rr_ptr was cleared by reset, so requester 1 wins over 3
      rr_run(4'b1010, 2, '{1, 3, 0, 0, 0, 0, 0, 0});

`ifdef FP_ARB_TIMEOUT_EN
      do_op(0, 64'h4000_0000_0000_0000, 64'h0, 10'h010, 2'd1, -1, 1'b0, 64'h0, 5'd0, lat_seen);
      check("timeout_latency", 64'(lat_seen), 64'd17);
`endif

      repeat (4) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

endmodule
